// File: rtl/uart_rx_tx_fifo.sv
// Byte FIFO between the UART receiver and transmitter handshakes.
// The head byte is visible on tx_data_o as soon as it is written (first-word fall-through).
module uart_rx_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  output logic              rx_ack_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_ready_o,
  input  logic              tx_ack_i,
  output logic [ADDR_W:0]   level_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level_o = wr_ptr - rd_ptr;

  // Gating with reset keeps both handshakes quiet while reset is held,
  // even though full_o reads 0 at that time.
  assign rx_ack_o   = reset & rx_ready_i & ~full_o  & ~flush_i;
  assign tx_ready_o = reset & tx_ack_i   & ~empty_o & ~flush_i;
  assign tx_data_o  = empty_o ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rx_ack_o)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_ready_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_ack_o) mem[wr_ptr[ADDR_W-1:0]] <= rx_data_i;
  end

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Bench for uart_rx_tx_fifo: accepted bytes go into a scoreboard queue,
// a negedge monitor pops and compares on every tx_ready_o strobe.
module tb_uart_rx_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic [7:0] rx_data_i;
  logic       rx_ready_i;
  logic       rx_ack_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_o;
  logic       tx_ack_i;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int max_level;
  logic [7:0] sb [$];

  uart_rx_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_i (rx_ready_i),
    .rx_ack_o   (rx_ack_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_o (tx_ready_o),
    .tx_ack_i   (tx_ack_i),
    .level_o    (level_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop on the transmit strobe first, then record an accepted byte.
  always @(negedge clk) begin
    if (tx_ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected got %0h expected none", tx_data_o);
      end else begin
        chk("tx_byte", {24'h0, tx_data_o}, {24'h0, sb.pop_front()});
      end
      n_out++;
    end
    if (rx_ack_o) sb.push_back(rx_data_i);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;

    // 1: reset holds everything quiet despite active requests
    reset = 1'b0; flush_i = 1'b0; rx_data_i = 8'hAA; rx_ready_i = 1'b1; tx_ack_i = 1'b1;
    repeat (3) step;
    at_neg;
    chk("rst_rx_ack",   rx_ack_o,   0);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_level",    level_o,    0);
    chk("rst_empty",    empty_o,    1);
    chk("rst_full",     full_o,     0);
    chk("rst_tx_data",  tx_data_o,  8'h00);
    rx_ready_i = 1'b0; tx_ack_i = 1'b0;
    #2 reset = 1'b1;

    // 2: single byte
    step;
    rx_data_i = 8'h41; rx_ready_i = 1'b1;
    at_neg;
    chk("single_ack", rx_ack_o, 1);
    chk("single_no_passthru", tx_ready_o, 0);
    step;
    rx_ready_i = 1'b0;
    at_neg;
    chk("single_ack_off", rx_ack_o,  0);
    chk("single_data",    tx_data_o, 8'h41);
    chk("single_level",   level_o,   1);
    chk("single_empty",   empty_o,   0);
    step;
    tx_ack_i = 1'b1;
    at_neg;
    chk("single_tx_ready", tx_ready_o, 1);
    step;
    tx_ack_i = 1'b0;
    at_neg;
    chk("single_drained",  empty_o,    1);
    chk("single_level0",   level_o,    0);
    chk("single_tx_data0", tx_data_o,  8'h00);

    // 3: fill to full, 17th request refused
    step;
    for (int i = 0; i < 16; i++) begin
      rx_data_i = 8'(i); rx_ready_i = 1'b1;
      step;
    end
    rx_data_i = 8'h10;
    at_neg;
    chk("fill_full",   full_o,   1);
    chk("fill_level",  level_o,  16);
    chk("fill_no_ack", rx_ack_o, 0);
    chk("fill_head",   tx_data_o, 8'h00);
    step;
    at_neg;
    chk("fill_no_ack2", rx_ack_o, 0);

    // 4: full with simultaneous read: write waits one cycle
    step;
    tx_ack_i = 1'b1;
    at_neg;
    chk("fullrd_tx_ready", tx_ready_o, 1);
    chk("fullrd_no_ack",   rx_ack_o,   0);
    step;
    tx_ack_i = 1'b0;
    at_neg;
    chk("fullrd_level15", level_o,  15);
    chk("fullrd_retry",   rx_ack_o, 1);
    step;
    rx_ready_i = 1'b0;
    at_neg;
    chk("fullrd_level16", level_o, 16);
    chk("fullrd_full",    full_o,  1);

    // drain 8'h01..8'h10 in order via the monitor
    step;
    tx_ack_i = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      at_neg;
      if (empty_o) drained = 1'b1;
      else step;
    end
    chk("drain_empty", drained, 1);
    chk("drain_sb",    sb.size(), 0);
    chk("drain_count", n_out, 18);
    step;
    tx_ack_i = 1'b0;

    // 5: streaming 40 bytes through, wrapping the pointers
    max_level = 0;
    rx_ready_i = 1'b1; tx_ack_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rx_data_i = 8'h80 + 8'(k);
      at_neg;
      if (int'(level_o) > max_level) max_level = int'(level_o);
      step;
    end
    rx_ready_i = 1'b0;
    at_neg;
    chk("stream_last_tx", tx_ready_o, 1);
    step;
    at_neg;
    chk("stream_empty", empty_o, 1);
    chk("stream_maxlvl_le1", (max_level <= 1), 1);
    chk("stream_count", n_out, 58);
    chk("stream_sb", sb.size(), 0);
    step;
    tx_ack_i = 1'b0;

    // 6a: flush at level 5
    for (int i = 0; i < 5; i++) begin
      rx_data_i = 8'hC0 + 8'(i); rx_ready_i = 1'b1;
      step;
    end
    rx_ready_i = 1'b0;
    at_neg;
    chk("flush_pre_level", level_o, 5);
    step;
    flush_i = 1'b1; rx_ready_i = 1'b1; rx_data_i = 8'hEE; tx_ack_i = 1'b1;
    at_neg;
    chk("flush_no_ack", rx_ack_o,   0);
    chk("flush_no_tx",  tx_ready_o, 0);
    sb.delete();
    step;
    flush_i = 1'b0; rx_ready_i = 1'b0; tx_ack_i = 1'b0;
    at_neg;
    chk("flush_level", level_o, 0);
    chk("flush_empty", empty_o, 1);

    // 6b: asynchronous reset between edges
    step;
    for (int i = 0; i < 3; i++) begin
      rx_data_i = 8'hD0 + 8'(i); rx_ready_i = 1'b1;
      step;
    end
    rx_data_i = 8'h77;
    at_neg;
    chk("arst_pre_level", level_o, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_empty",  empty_o,   1);
    chk("arst_level",  level_o,   0);
    chk("arst_rx_ack", rx_ack_o,  0);
    chk("arst_data",   tx_data_o, 8'h00);
    sb.delete();
    rx_ready_i = 1'b0;
    step;
    reset = 1'b1;
    rx_data_i = 8'h5A; rx_ready_i = 1'b1;
    step;
    rx_ready_i = 1'b0; tx_ack_i = 1'b1;
    at_neg;
    chk("post_rst_data", tx_data_o, 8'h5A);
    step;
    tx_ack_i = 1'b0;
    at_neg;
    chk("post_rst_empty", empty_o, 1);
    chk("post_rst_count", n_out, 59);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
